// File: rtl/msk_gadget_sched_if.sv
// Bundle between the masked-gadget scheduler, its requesters and the shared gadget.
// The scheduler uses the slave view; requesters plus the gadget sit on the master view.
interface msk_gadget_sched_if #(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1,
  parameter int unsigned NREQ  = 4
);
  localparam int unsigned W = count * d;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_inv;
  logic              rnd_valid;
  logic              g_in_valid;
  logic [W-1:0]      g_a;
  logic [W-1:0]      g_b;
  logic [W-1:0]      g_out;
  logic [NREQ-1:0]   resp_valid;
  logic [W-1:0]      resp_data;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, req_inv, rnd_valid, g_out,
    input  req_ready, g_in_valid, g_a, g_b, resp_valid, resp_data, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_inv, rnd_valid, g_out,
    output req_ready, g_in_valid, g_a, g_b, resp_valid, resp_data, busy
  );
endinterface

// File: rtl/msk_gadget_sched.sv
// Round-robin time-sharing of one pipelined two-input masked gadget among NREQ requesters.
// Optional macro MSK_SCHED_INV_EN: per-request complement of the result (share 0 of each bit flipped).
module msk_gadget_sched #(
  parameter int unsigned d     = 2,
  parameter int unsigned count = 1,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LAT   = 2
) (
  input logic               clk,
  input logic               rst_n,
  msk_gadget_sched_if.slave bus
);
  localparam int unsigned W  = count * d;
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [NREQ-1:0] grant;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  logic            g_in_valid_q;
  logic [W-1:0]    g_a_q;
  logic [W-1:0]    g_b_q;
  logic [PW-1:0]   iss_tag;

  logic [LAT-1:0]  st_v;
  logic [PW-1:0]   st_tag [LAT];

  logic [NREQ-1:0] rsp_v_nxt;
  logic [W-1:0]    rsp_d_nxt;
  logic [NREQ-1:0] rsp_v_q;
  logic [W-1:0]    rsp_d_q;

`ifdef MSK_SCHED_INV_EN
  logic            sel_inv;
  logic            iss_inv;
  logic [LAT-1:0]  st_inv;

  function automatic logic [W-1:0] share0_mask();
    logic [W-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < count; k++) m[k*d] = 1'b1;
    return m;
  endfunction

  localparam logic [W-1:0] INV_MASK = share0_mask();
`else
  logic unused_inv;
  assign unused_inv = ^bus.req_inv;
`endif

  // Rotating-priority search starting at ptr; gated by fresh randomness.
  always_comb begin : arb
    int unsigned j;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    if (bus.rnd_valid) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        j = (32'(ptr) + k) % NREQ;
        if (!gnt_any && bus.req_valid[j]) begin
          gnt_any = 1'b1;
          gnt_idx = PW'(j);
        end
      end
    end
    if (gnt_any) grant[gnt_idx] = 1'b1;
  end

  // Operand select: one-hot grant, all-zero when nothing is granted.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
`ifdef MSK_SCHED_INV_EN
    sel_inv = 1'b0;
`endif
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = bus.req_a[i*W +: W];
        sel_b = bus.req_b[i*W +: W];
`ifdef MSK_SCHED_INV_EN
        sel_inv = bus.req_inv[i];
`endif
      end
    end
  end

  // Issue register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= '0;
      g_in_valid_q <= 1'b0;
      g_a_q        <= '0;
      g_b_q        <= '0;
      iss_tag      <= '0;
`ifdef MSK_SCHED_INV_EN
      iss_inv      <= 1'b0;
`endif
    end else begin
      g_in_valid_q <= gnt_any;
      g_a_q        <= sel_a;
      g_b_q        <= sel_b;
      iss_tag      <= gnt_idx;
`ifdef MSK_SCHED_INV_EN
      iss_inv      <= sel_inv;
`endif
      if (gnt_any) ptr <= (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Tag pipeline tracking the gadget's fixed latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_v <= '0;
      for (int unsigned k = 0; k < LAT; k++) st_tag[k] <= '0;
`ifdef MSK_SCHED_INV_EN
      st_inv <= '0;
`endif
    end else begin
      st_v[0]   <= g_in_valid_q;
      st_tag[0] <= iss_tag;
`ifdef MSK_SCHED_INV_EN
      st_inv[0] <= iss_inv;
`endif
      for (int unsigned k = 1; k < LAT; k++) begin
        st_v[k]   <= st_v[k-1];
        st_tag[k] <= st_tag[k-1];
`ifdef MSK_SCHED_INV_EN
        st_inv[k] <= st_inv[k-1];
`endif
      end
    end
  end

  always_comb begin
    rsp_v_nxt = '0;
    rsp_d_nxt = '0;
    if (st_v[LAT-1]) begin
      rsp_v_nxt[st_tag[LAT-1]] = 1'b1;
`ifdef MSK_SCHED_INV_EN
      rsp_d_nxt = bus.g_out ^ (st_inv[LAT-1] ? INV_MASK : '0);
`else
      rsp_d_nxt = bus.g_out;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_v_q <= '0;
      rsp_d_q <= '0;
    end else begin
      rsp_v_q <= rsp_v_nxt;
      rsp_d_q <= rsp_d_nxt;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.g_in_valid = g_in_valid_q;
  assign bus.g_a        = g_a_q;
  assign bus.g_b        = g_b_q;
  assign bus.resp_valid = rsp_v_q;
  assign bus.resp_data  = rsp_d_q;
  assign bus.busy       = g_in_valid_q | (|st_v) | (|rsp_v_q);
endmodule

// File: tb/tb_msk_gadget_sched.sv
// Scoreboard bench for msk_gadget_sched (d=2, count=1, NREQ=4, LAT=2) with a toy gadget model.
module tb_msk_gadget_sched;
  localparam int unsigned LAT = 2;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct packed {
    logic [3:0] strobe;
    logic [1:0] data;
  } exp_t;
  exp_t sb[$];

  msk_gadget_sched_if #(.d(2), .count(1), .NREQ(4)) bus ();

  msk_gadget_sched #(.d(2), .count(1), .NREQ(4), .LAT(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Gadget stand-in: a ^ b after LAT cycles, 2'b11 garbage when nothing was issued.
  logic [1:0] gpipe [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LAT; k++) gpipe[k] <= 2'b11;
    end else begin
      gpipe[0] <= bus.g_in_valid ? (bus.g_a ^ bus.g_b) : 2'b11;
      for (int k = 1; k < LAT; k++) gpipe[k] <= gpipe[k-1];
    end
  end
  assign bus.g_out = gpipe[LAT-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a response strobe appears.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.resp_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(bus.resp_valid), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_valid", 32'(bus.resp_valid), 32'(e.strobe));
          chk("resp_data", 32'(bus.resp_data), 32'(e.data));
        end
      end else begin
        chk("resp_data_idle", 32'(bus.resp_data), 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] v, input logic [3:0] inv, input logic rnd,
                       input logic [7:0] a, input logic [7:0] b, input logic [3:0] eg,
                       input logic [1:0] ed, input logic [1:0] edi, input bit push);
    exp_t e;
    bus.req_valid = v;
    bus.req_inv   = inv;
    bus.rnd_valid = rnd;
    bus.req_a     = a;
    bus.req_b     = b;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    if (push && eg != 4'b0000) begin
      e.strobe = eg;
`ifdef MSK_SCHED_INV_EN
      e.data = edi;
`else
      e.data = ed;
`endif
      sb.push_back(e);
    end
    tick();
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_inv   = '0;
    bus.rnd_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'h0);
    tick();
    tick();
    chk("busy_after_drain", 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0] RR_A = 8'b11_10_01_00;
  localparam logic [7:0] RR_B = 8'hFF;

  initial begin
    rst_n = 1'b0;
    idle();
    #1;
    chk("rst_g_in_valid", 32'(bus.g_in_valid), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    #21 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_g_in_valid", 32'(bus.g_in_valid), 32'h0);
      chk("idle_g_ab", 32'({bus.g_a, bus.g_b}), 32'h0);
      chk("idle_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("idle_busy", 32'(bus.busy), 32'h0);
    end

    // Single request from slot 2; exact latency check.
    issue(4'b0100, 4'b0000, 1'b1, 8'b00_10_00_00, 8'h00, 4'b0100, 2'b10, 2'b10, 1'b1);
    idle();
    chk("single_g_in_valid", 32'(bus.g_in_valid), 32'h1);
    chk("single_g_a", 32'(bus.g_a), 32'h2);
    chk("single_g_b", 32'(bus.g_b), 32'h0);
    chk("single_busy", 32'(bus.busy), 32'h1);
    tick();
    tick();
    chk("single_resp_early", 32'(bus.resp_valid), 32'h0);
    tick();
    chk("single_resp_at_4", 32'(bus.resp_valid), 32'h4);
    drain();

    // Round robin from ptr=3 (left by the slot-2 grant).
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b1000, 2'b00, 2'b00, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b0001, 2'b11, 2'b11, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b0010, 2'b10, 2'b10, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b0100, 2'b01, 2'b01, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b1000, 2'b00, 2'b00, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b0001, 2'b11, 2'b11, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b0010, 2'b10, 2'b10, 1'b1);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b0100, 2'b01, 2'b01, 1'b1);

    // Randomness stall: grant 3, nothing, then 0 (pointer held across the gap).
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b1000, 2'b00, 2'b00, 1'b1);
    issue(4'b1111, 4'b0000, 1'b0, RR_A, RR_B, 4'b0000, 2'b00, 2'b00, 1'b1);
    chk("stall_g_in_valid", 32'(bus.g_in_valid), 32'h0);
    chk("stall_g_a", 32'(bus.g_a), 32'h0);
    chk("stall_g_b", 32'(bus.g_b), 32'h0);
    issue(4'b1111, 4'b0000, 1'b1, RR_A, RR_B, 4'b0001, 2'b11, 2'b11, 1'b1);
    idle();
    drain();

    // Reset mid-flight: two grants discarded, async assertion clears issue stage at once.
    issue(4'b0001, 4'b0000, 1'b1, 8'h01, 8'h00, 4'b0001, 2'b01, 2'b01, 1'b0);
    issue(4'b0010, 4'b0000, 1'b1, 8'h04, 8'h00, 4'b0010, 2'b01, 2'b01, 1'b0);
    idle();
    chk("mid_g_in_valid_pre", 32'(bus.g_in_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_g_in_valid_rst", 32'(bus.g_in_valid), 32'h0);
    chk("mid_busy_rst", 32'(bus.busy), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy_after", 32'(bus.busy), 32'h0);

    // Inversion: slot 1 with inv, then slot 0 without (ptr=0 after reset).
    issue(4'b0010, 4'b0010, 1'b1, 8'b00_00_01_00, 8'h00, 4'b0010, 2'b01, 2'b00, 1'b1);
    issue(4'b0001, 4'b0000, 1'b1, 8'b00_00_00_10, 8'b00_00_00_11, 4'b0001, 2'b01, 2'b01, 1'b1);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
